// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main sequencer for the multicycle RV32 datapath.
module multicycle_ctrl_fsm #(
  parameter int MEM_LAT = 1,
  parameter int BRANCH_BUBBLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [6:0] instOpcode,
  input  logic       mem_ready,
  output logic       IorDSelector,
  output logic       ce,
  output logic       oce,
  output logic       wre,
  output logic       irWriteEnable,
  output logic       pcWriteEnable,
  output logic       pcWriteCond,
  output logic [1:0] pcSource,
  output logic [1:0] memtoRegSelect,
  output logic       regWriteEnable,
  output logic       aluSrcASelect,
  output logic [1:0] aluSrcBSelect,
  output logic [1:0] aluOp,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, LOAD_WB, MEM_WR, EXEC_R,
    EXEC_I, ALU_WB, BRANCH, BR_BUBBLE, JAL, TRAP
  } state_t;
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  state_t state;
  logic [3:0] wait_cnt;
  logic mem_st, mem_done;
  always_comb begin
    mem_st = state inside {FETCH, MEM_RD, MEM_WR};
    mem_done = mem_st && wait_cnt == LAST && mem_ready;
    IorDSelector = state inside {MEM_RD, MEM_WR};
    ce = mem_st;
    oce = mem_st;
    wre = state == MEM_WR;
    irWriteEnable = state == FETCH && mem_done;
    pcWriteEnable = (state == FETCH && mem_done) || state == JAL;
    pcWriteCond = state == BRANCH;
    pcSource = state == BRANCH ? 2'b01 : state == JAL ? 2'b10 : 2'b00;
    memtoRegSelect = state == LOAD_WB ? 2'b01 : state == JAL ? 2'b10 : 2'b00;
    regWriteEnable = state inside {LOAD_WB, ALU_WB, JAL};
    aluSrcASelect = state inside {MEM_ADDR, EXEC_R, EXEC_I, BRANCH};
    aluSrcBSelect = state == FETCH ? 2'b01 : state inside {DECODE, MEM_ADDR, EXEC_I} ? 2'b10 : 2'b00;
    aluOp = state == EXEC_R ? 2'b10 :
            state == EXEC_I ? (instOpcode == 7'h37 ? 2'b11 : 2'b10) :
            state == BRANCH ? 2'b01 : 2'b00;
    instr_done = state inside {LOAD_WB, ALU_WB, BR_BUBBLE, JAL} ||
                 (state == MEM_WR && mem_done) || (state == BRANCH && BRANCH_BUBBLE == 0);
    trap = state == TRAP;
    state_o = state;
  end
  // wait_cnt only moves while an access is held; every exit leaves it cleared for the next entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (mem_st && !mem_done) ? (wait_cnt == LAST ? wait_cnt : wait_cnt + 4'd1) : '0;
      if (instr_done) state <= run ? FETCH : IDLE;
      else
        case (state)
          IDLE:     state <= run ? FETCH : IDLE;
          FETCH:    if (mem_done) state <= DECODE;
          DECODE:   state <= (instOpcode == 7'h03 || instOpcode == 7'h23) ? MEM_ADDR :
                             instOpcode == 7'h33 ? EXEC_R :
                             (instOpcode == 7'h13 || instOpcode == 7'h37) ? EXEC_I :
                             instOpcode == 7'h63 ? BRANCH :
                             instOpcode == 7'h6F ? JAL : TRAP;
          MEM_ADDR: state <= instOpcode == 7'h03 ? MEM_RD : MEM_WR;
          MEM_RD:   if (mem_done) state <= LOAD_WB;
          MEM_WR:   state <= MEM_WR;
          EXEC_R, EXEC_I: state <= ALU_WB;
          BRANCH:   state <= BR_BUBBLE;
          TRAP:     state <= TRAP;
          default:  state <= IDLE;
        endcase
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Parametrised main controller for the multicycle RV32 datapath.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath enable and select.
- Supported instruction classes: load, store, R-type, I-type ALU, branch, JAL and LUI.
- Supports variable-latency memory through a wait counter plus a ready handshake, a run/stop control, an optional post-branch bubble, and an illegal-opcode trap.

Parameters:
- MEM_LAT, 1: minimum cycles a memory access holds ce before completion may be recognised (legal range 1..15).
- BRANCH_BUBBLE, 1: 1 inserts one idle cycle after BRANCH so the new PC settles before fetch; 0 disables it.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  start/continue execution; sampled in IDLE and at each instruction boundary
- instOpcode  in  7  opcode field of the instruction register
- mem_ready  in  1  memory ready; an access completes only when this is high
- IorDSelector  out  1  memory address select: 0 = PC, 1 = ALUOut
- ce  out  1  memory clock enable
- oce  out  1  memory output clock enable
- wre  out  1  memory write enable
- irWriteEnable  out  1  instruction register load
- pcWriteEnable  out  1  unconditional PC write
- pcWriteCond  out  1  PC write when ALU zero is set
- pcSource  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = ALUOut (jump target)
- memtoRegSelect  out  2  register file write data: 00 = ALUOut, 01 = MDR, 10 = PC
- regWriteEnable  out  1  register file write
- aluSrcASelect  out  1  ALU A source: 0 = PC, 1 = rs1
- aluSrcBSelect  out  2  ALU B source: 00 = rs2, 01 = constant 4, 10 = immediate
- aluOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct-decoded, 11 = pass B
- instr_done  out  1  one-cycle pulse when an instruction completes
- trap  out  1  illegal opcode seen; sticky until reset
- state_o  out  4  current state code, for debug

Behaviour:
- Reset: asynchronous. state = IDLE, wait_cnt = 0, trap = 0. All outputs are combinational from state and are 0 in IDLE. Reset asserted in any state, including mid-access, aborts immediately; no write completes.
- Unlisted outputs default to 0 in every state.
- State codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, LOAD_WB 5, MEM_WR 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, BRANCH 10, BR_BUBBLE 11, JAL 12, TRAP 13. Codes 14 and 15 go to IDLE with all outputs 0.
- Memory access rule (FETCH, MEM_RD, MEM_WR):
  - ce = oce = 1 on every cycle of the state.
  - wait_cnt clears on entry and increments each cycle the state is held, saturating at MEM_LAT-1.
  - The access completes on the cycle where wait_cnt == MEM_LAT-1 and mem_ready = 1; the state then exits.
  - Otherwise the state is held with outputs stable.
- IDLE: go to FETCH when run = 1.
- FETCH: IorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 00. irWriteEnable, pcWriteEnable and pcSource = 00 assert only on the completion cycle, so PC+4 is written exactly once. Next state: DECODE.
- DECODE: aluSrcA = 0, aluSrcB = 10, aluOp = 00, which precomputes the branch/jump target into ALUOut. Dispatch on instOpcode:
  - 0x03 or 0x23 -> MEM_ADDR
  - 0x33 -> EXEC_R
  - 0x13 -> EXEC_I
  - 0x37 -> EXEC_I (LUI)
  - 0x63 -> BRANCH
  - 0x6F -> JAL
  - anything else -> TRAP
- MEM_ADDR: aluSrcA = 1, aluSrcB = 10, aluOp = 00. Next: MEM_RD if opcode is 0x03, else MEM_WR.
- MEM_RD: IorD = 1 plus the access rule. Next: LOAD_WB.
- MEM_WR: IorD = 1, wre = 1 plus the access rule. Boundary step.
- LOAD_WB: memtoReg = 01, regWriteEnable = 1. Boundary step.
- EXEC_R: aluSrcA = 1, aluSrcB = 00, aluOp = 10. Next: ALU_WB.
- EXEC_I: aluSrcA = 1, aluSrcB = 10. aluOp = 11 when opcode is 0x37, else 10. Next: ALU_WB.
- ALU_WB: memtoReg = 00, regWriteEnable = 1. Boundary step.
- BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 01, pcWriteCond = 1, pcSource = 01. Next: BR_BUBBLE if BRANCH_BUBBLE = 1, else boundary step.
- BR_BUBBLE: no outputs asserted. Boundary step.
- JAL: regWriteEnable = 1, memtoReg = 10 (PC already holds PC+4), pcWriteEnable = 1, pcSource = 10, all in the same cycle. Boundary step.
- Boundary step: instr_done = 1 for that cycle. Next state is FETCH if run = 1, else IDLE. Dropping run never aborts an instruction in flight.
- TRAP: trap = 1, all other outputs 0. Held until reset; run and mem_ready are ignored.
- mem_ready is ignored outside memory states. mem_ready held high with MEM_LAT = 1 gives a single-cycle access.

Test Plan:
- MEM_LAT = 1, mem_ready = 1, run = 1, R-type (0x33): state_o sequence 1,2,7,9,1. irWriteEnable is high for exactly 1 cycle. instr_done pulses in state 9.
- MEM_LAT = 3, mem_ready = 1, load (0x03): FETCH lasts 3 cycles and MEM_RD lasts 3 cycles. pcWriteEnable rises only on the 3rd fetch cycle. regWriteEnable = 1 with memtoReg = 01 in state 5.
- MEM_LAT = 1, store (0x23) with mem_ready held low 4 cycles: MEM_WR lasts 5 cycles with wre = 1 and IorD = 1 throughout; exits on the cycle mem_ready rises.
- Branch (0x63) with BRANCH_BUBBLE = 1, then 0: state_o shows 10,11,1 in the first case and 10,1 in the second. pcSource = 01 and pcWriteCond = 1 only in state 10.
- JAL (0x6F), then opcode 0x7F: JAL asserts regWriteEnable, pcWriteEnable, memtoReg = 10 and pcSource = 10 in one cycle. 0x7F drives state_o = 13 and trap = 1, which stay set through 20 cycles with run = 1.
- run dropped mid-load, then rst pulsed mid-FETCH with MEM_LAT = 3: the load completes and the FSM returns to IDLE (0). The reset cycle forces state_o = 0, all outputs 0, trap = 0.
